// File: rtl/sweep_pkg.sv
// Shared sweep definitions: state encodings, direction constants and default widths.
// Direction encoding matches the sweep generator (0 = going up, 1 = going down).
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      SCAN = 2'd2
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   localparam int SIGNAL_IN_SIZE_DEF = 16;
   localparam int POS_SIZE_DEF       = 16;
   localparam int CNT_SIZE           = 16;

endpackage

// File: rtl/sweep_peak_finder_if.sv
// Sample-in / peak-result-out bundle of sweep_peak_finder; master drives samples, slave is the finder.
// SWEEP_PEAK_THRESH_EN adds thresh_in and found_out.
interface sweep_peak_finder_if
   import sweep_pkg::*;
#(
   parameter int SIGNAL_IN_SIZE = SIGNAL_IN_SIZE_DEF,
   parameter int POS_SIZE       = POS_SIZE_DEF
);
   logic                             on_in;
   logic signed [POS_SIZE-1:0]       sweep_val_in;
   logic signed [SIGNAL_IN_SIZE-1:0] signal_in;
   logic                             signal_valid_in;
   logic signed [SIGNAL_IN_SIZE-1:0] peak_val_out;
   logic signed [POS_SIZE-1:0]       peak_pos_out;
   logic                             peak_dir_out;
   logic                             done_out;
   logic [CNT_SIZE-1:0]              scan_count_out;
`ifdef SWEEP_PEAK_THRESH_EN
   logic signed [SIGNAL_IN_SIZE-1:0] thresh_in;
   logic                             found_out;
`endif

   modport master (
      output on_in, sweep_val_in, signal_in, signal_valid_in,
`ifdef SWEEP_PEAK_THRESH_EN
      output thresh_in,
      input  found_out,
`endif
      input  peak_val_out, peak_pos_out, peak_dir_out, done_out, scan_count_out
   );

   modport slave (
      input  on_in, sweep_val_in, signal_in, signal_valid_in,
`ifdef SWEEP_PEAK_THRESH_EN
      input  thresh_in,
      output found_out,
`endif
      output peak_val_out, peak_pos_out, peak_dir_out, done_out, scan_count_out
   );

endinterface

// File: rtl/sweep_dir_detect.sv
// Tracks sweep direction from successive samples; turn_out is combinational in the turnaround cycle.
// Equal successive values never change direction; clear_in forces direction up and masks turn_out.
module sweep_dir_detect
   import sweep_pkg::*;
#(
   parameter int POS_SIZE = POS_SIZE_DEF
) (
   input  logic                       clk_in,
   input  logic                       rst_n_in,
   input  logic                       clear_in,
   input  logic signed [POS_SIZE-1:0] sweep_val_in,
   output logic                       dir_out,
   output logic                       turn_out
);

   logic signed [POS_SIZE-1:0] r_prev;
   logic                       r_dir;
   logic                       w_inc;
   logic                       w_dec;

   always_comb begin
      w_inc = (sweep_val_in > r_prev);
      w_dec = (sweep_val_in < r_prev);
   end

   assign turn_out = !clear_in &&
                     ((w_inc && (r_dir == DIR_DOWN)) || (w_dec && (r_dir == DIR_UP)));
   assign dir_out  = r_dir;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_prev <= '0;
         r_dir  <= DIR_UP;
      end else begin
         r_prev <= sweep_val_in;
         if (clear_in)
            r_dir <= DIR_UP;
         else if (w_inc)
            r_dir <= DIR_UP;
         else if (w_dec)
            r_dir <= DIR_DOWN;
      end
   end

endmodule

// File: rtl/sweep_peak_finder.sv
// Per half-scan peak finder: results and done_out appear one cycle after the turnaround; no back-pressure.
// SWEEP_PEAK_THRESH_EN adds found_out = (peak >= thresh_in) at publish time.
module sweep_peak_finder
   import sweep_pkg::*;
#(
   parameter int SIGNAL_IN_SIZE = SIGNAL_IN_SIZE_DEF,
   parameter int POS_SIZE       = POS_SIZE_DEF
) (
   input logic               clk_in,
   input logic               rst_n_in,
   sweep_peak_finder_if.slave bus
);

   state_t                           r_state;
   state_t                           w_state_nxt;
   logic                             w_publish;
   logic                             w_turn;
   logic                             w_dir;
   logic                             w_clear;

   logic                             r_trk_vld;
   logic signed [SIGNAL_IN_SIZE-1:0] r_trk_val;
   logic signed [POS_SIZE-1:0]       r_trk_pos;

   logic signed [SIGNAL_IN_SIZE-1:0] r_peak_val;
   logic signed [POS_SIZE-1:0]       r_peak_pos;
   logic                             r_peak_dir;
   logic                             r_done;
   logic [CNT_SIZE-1:0]              r_count;

   assign w_clear = (r_state == IDLE);

   sweep_dir_detect #(.POS_SIZE(POS_SIZE)) u_dir (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .clear_in     (w_clear),
      .sweep_val_in (bus.sweep_val_in),
      .dir_out      (w_dir),
      .turn_out     (w_turn)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n_in)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_publish   = 1'b0;
      if (!bus.on_in) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    w_state_nxt = ARM;
            ARM:     if (w_turn) w_state_nxt = SCAN;
            SCAN:    w_publish = w_turn && r_trk_vld;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // The turnaround sample opens the new half-scan, so it reloads rather than competes.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_trk_vld <= 1'b0;
         r_trk_val <= '0;
         r_trk_pos <= '0;
      end else if (!bus.on_in || (r_state == IDLE)) begin
         r_trk_vld <= 1'b0;
      end else if (w_turn) begin
         r_trk_vld <= bus.signal_valid_in;
         r_trk_val <= bus.signal_in;
         r_trk_pos <= bus.sweep_val_in;
      end else if (bus.signal_valid_in && (!r_trk_vld || (bus.signal_in > r_trk_val))) begin
         r_trk_vld <= 1'b1;
         r_trk_val <= bus.signal_in;
         r_trk_pos <= bus.sweep_val_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_peak_val <= '0;
         r_peak_pos <= '0;
         r_peak_dir <= DIR_UP;
         r_done     <= 1'b0;
         r_count    <= '0;
      end else begin
         r_done <= w_publish;
         if (w_publish) begin
            r_peak_val <= r_trk_val;
            r_peak_pos <= r_trk_pos;
            r_peak_dir <= w_dir;
            r_count    <= r_count + 1'b1;
         end
      end
   end

`ifdef SWEEP_PEAK_THRESH_EN
   logic r_found;

   always_ff @(posedge clk_in) begin
      if (!rst_n_in)
         r_found <= 1'b0;
      else if (w_publish)
         r_found <= (r_trk_val >= bus.thresh_in);
   end

   assign bus.found_out = r_found;
`endif

   assign bus.peak_val_out   = r_peak_val;
   assign bus.peak_pos_out   = r_peak_pos;
   assign bus.peak_dir_out   = r_peak_dir;
   assign bus.done_out       = r_done;
   assign bus.scan_count_out = r_count;

endmodule

// File: tb/tb_sweep_peak_finder.sv
// Bench for sweep_peak_finder: fixed vector table, directed sweeps and a random run, all against
// a half-scan reference model that buffers each half-scan's samples and searches for the maximum.
module tb_sweep_peak_finder;
   import sweep_pkg::*;

   localparam int SW = 16;
   localparam int PW = 16;

   logic clk_in   = 1'b0;
   logic rst_n_in = 1'b0;
   always #5 clk_in = ~clk_in;

   sweep_peak_finder_if #(.SIGNAL_IN_SIZE(SW), .POS_SIZE(PW)) bus ();

   sweep_peak_finder #(.SIGNAL_IN_SIZE(SW), .POS_SIZE(PW)) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .bus      (bus)
   );

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   // reference model state
   int  m_prev;
   bit  m_dir, m_idle, m_armed;
   int  seg_val[$];
   int  seg_pos[$];
   int  e_val, e_pos, e_cnt;
   bit  e_dir, e_done, e_found;
   int  thresh = 0;

   // published results seen on the DUT
   int  q_val[$];
   int  q_pos[$];
   int  q_cnt[$];
   bit  q_dir[$];
   bit  q_found[$];

   // detector shape used by the directed ramps
   bit  eq_mode = 1'b0;
   int  pk_val  = 1000;
   int  pk_pos  = 40;

   typedef struct {
      bit on; int sw; int sg; bit v;
      bit d; int val; int pos; bit dir; int cnt;
   } vec_t;
   vec_t tv[12];

   function automatic int sigf(input int p);
      if (eq_mode)
         return ((p == -20) || (p == 30)) ? 500 : 100;
      return pk_val - ((p > pk_pos) ? (p - pk_pos) : (pk_pos - p));
   endfunction

   task automatic model(input bit rst, input bit on, input int sw, input int sg, input bit v);
      int best;
      bit nd;
      e_done = 1'b0;
      if (!rst) begin
         e_val = 0; e_pos = 0; e_dir = 1'b0; e_cnt = 0; e_found = 1'b0;
         m_prev = 0; m_dir = 1'b0; m_idle = 1'b1; m_armed = 1'b0;
         seg_val.delete(); seg_pos.delete();
      end else begin
         if (!on) begin
            m_idle = 1'b1; m_dir = 1'b0;
            seg_val.delete(); seg_pos.delete();
         end else if (m_idle) begin
            m_idle = 1'b0; m_armed = 1'b0; m_dir = 1'b0;
            seg_val.delete(); seg_pos.delete();
         end else begin
            if (sw != m_prev) begin
               nd = (sw < m_prev);
               if (nd != m_dir) begin
                  if (m_armed && (seg_val.size() > 0)) begin
                     best = 0;
                     for (int i = 1; i < seg_val.size(); i++)
                        if (seg_val[i] > seg_val[best]) best = i;
                     e_val   = seg_val[best];
                     e_pos   = seg_pos[best];
                     e_dir   = m_dir;
                     e_done  = 1'b1;
                     e_cnt   = (e_cnt + 1) % 65536;
                     e_found = (seg_val[best] >= thresh);
                  end
                  m_armed = 1'b1;
                  seg_val.delete(); seg_pos.delete();
               end
               m_dir = nd;
            end
            if (v) begin
               seg_val.push_back(sg);
               seg_pos.push_back(sw);
            end
         end
         m_prev = sw;
      end
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, got, exp);
   endtask

   task automatic step(input bit rst, input bit on, input int sw, input int sg, input bit v);
      bit ok;
      rst_n_in            = rst;
      bus.on_in           = on;
      bus.sweep_val_in    = PW'(sw);
      bus.signal_in       = SW'(sg);
      bus.signal_valid_in = v;
`ifdef SWEEP_PEAK_THRESH_EN
      bus.thresh_in       = SW'(thresh);
`endif
      @(posedge clk_in);
      model(rst, on, sw, sg, v);
      #1;
      cyc++;
      ok = (bus.done_out === e_done) && (bus.peak_val_out === SW'(e_val)) &&
           (bus.peak_pos_out === PW'(e_pos)) && (bus.peak_dir_out === e_dir) &&
           (bus.scan_count_out === 16'(e_cnt));
`ifdef SWEEP_PEAK_THRESH_EN
      ok = ok && (bus.found_out === e_found);
`endif
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL cyc%0d outputs: got done=%0b val=%0d pos=%0d dir=%0b cnt=%0d, want done=%0b val=%0d pos=%0d dir=%0b cnt=%0d",
                    cyc, bus.done_out, bus.peak_val_out, bus.peak_pos_out, bus.peak_dir_out, bus.scan_count_out,
                    e_done, e_val, e_pos, e_dir, e_cnt);
      if (bus.done_out === 1'b1) begin
         q_val.push_back(int'(bus.peak_val_out));
         q_pos.push_back(int'(bus.peak_pos_out));
         q_cnt.push_back(int'(bus.scan_count_out));
         q_dir.push_back(bus.peak_dir_out);
`ifdef SWEEP_PEAK_THRESH_EN
         q_found.push_back(bus.found_out);
`else
         q_found.push_back(1'b0);
`endif
      end
   endtask

   task automatic clear_q();
      q_val.delete(); q_pos.delete(); q_cnt.delete(); q_dir.delete(); q_found.delete();
   endtask

   task automatic ramp(input int from, input int to, input int hold, input bit v);
      int s = (to >= from) ? 1 : -1;
      int n = (to - from) * s;
      int p;
      for (int k = 0; k <= n; k++) begin
         p = from + k * s;
         for (int h = 0; h < hold; h++) step(1'b1, 1'b1, p, sigf(p), v);
      end
   endtask

   task automatic reset_checks(input string tag);
      step(1'b0, 1'b0, 0, 0, 1'b0);
      check({tag, "_val"},  int'(bus.peak_val_out), 0);
      check({tag, "_pos"},  int'(bus.peak_pos_out), 0);
      check({tag, "_dir"},  int'(bus.peak_dir_out), 0);
      check({tag, "_done"}, int'(bus.done_out), 0);
      check({tag, "_cnt"},  int'(bus.scan_count_out), 0);
`ifdef SWEEP_PEAK_THRESH_EN
      check({tag, "_found"}, int'(bus.found_out), 0);
`endif
   endtask

   initial begin
      int pos, dir, amp, off_left;
      bus.on_in = 1'b0; bus.sweep_val_in = '0; bus.signal_in = '0; bus.signal_valid_in = 1'b0;
`ifdef SWEEP_PEAK_THRESH_EN
      bus.thresh_in = '0;
`endif
      step(1'b0, 1'b0, 0, 0, 1'b0);
      reset_checks("reset");

      // short hand-worked triangle: ties, equal holds, an invalid sample
      tv[0]  = '{1,  0,   5, 1,  0, 0, 0, 0, 0};
      tv[1]  = '{1,  1,   7, 1,  0, 0, 0, 0, 0};
      tv[2]  = '{1,  2,   3, 1,  0, 0, 0, 0, 0};
      tv[3]  = '{1,  1,   9, 1,  0, 0, 0, 0, 0};
      tv[4]  = '{1,  0,   4, 1,  0, 0, 0, 0, 0};
      tv[5]  = '{1, -1,   9, 1,  0, 0, 0, 0, 0};
      tv[6]  = '{1,  0,   2, 1,  1, 9, 1, 1, 1};
      tv[7]  = '{1,  1,   6, 1,  0, 9, 1, 1, 1};
      tv[8]  = '{1,  1,   8, 1,  0, 9, 1, 1, 1};
      tv[9]  = '{1,  0,   1, 1,  1, 8, 1, 0, 2};
      tv[10] = '{1, -1, 100, 0,  0, 8, 1, 0, 2};
      tv[11] = '{1,  0,   0, 1,  1, 1, 0, 1, 3};
      for (int i = 0; i < 12; i++) begin
         step(1'b1, tv[i].on, tv[i].sw, tv[i].sg, tv[i].v);
         n_total++;
         if ((bus.done_out === tv[i].d) && (bus.peak_val_out === SW'(tv[i].val)) &&
             (bus.peak_pos_out === PW'(tv[i].pos)) && (bus.peak_dir_out === tv[i].dir) &&
             (bus.scan_count_out === 16'(tv[i].cnt)))
            n_pass++;
         else
            $display("FAIL vec%0d: got done=%0b val=%0d pos=%0d dir=%0b cnt=%0d, want done=%0b val=%0d pos=%0d dir=%0b cnt=%0d",
                     i, bus.done_out, bus.peak_val_out, bus.peak_pos_out, bus.peak_dir_out, bus.scan_count_out,
                     tv[i].d, tv[i].val, tv[i].pos, tv[i].dir, tv[i].cnt);
      end

      // full triangle 0 -> +100 -> -100 -> +100, detector peaked at +40
      reset_checks("rst2");
      eq_mode = 1'b0; pk_val = 1000; pk_pos = 40; clear_q();
      ramp(0, 100, 1, 1'b1);
      ramp(99, -100, 1, 1'b1);
      check("tri_no_done_first", q_val.size(), 0);
      ramp(-99, 100, 1, 1'b1);
      ramp(99, 99, 1, 1'b1);
      check("tri_ndone", q_val.size(), 2);
      if (q_val.size() == 2) begin
         check("tri0_val", q_val[0], 1000); check("tri0_pos", q_pos[0], 40);
         check("tri0_dir", q_dir[0], 1);    check("tri0_cnt", q_cnt[0], 1);
         check("tri1_val", q_val[1], 1000); check("tri1_pos", q_pos[1], 40);
         check("tri1_dir", q_dir[1], 0);    check("tri1_cnt", q_cnt[1], 2);
      end

      // two equal maxima on an up-scan: earliest position wins
      reset_checks("rst3");
      eq_mode = 1'b1; clear_q();
      ramp(0, 1, 1, 1'b1);
      ramp(0, -50, 1, 1'b1);
      ramp(-49, 50, 1, 1'b1);
      ramp(49, 49, 1, 1'b1);
      check("tie_ndone", q_val.size(), 2);
      if (q_val.size() == 2) begin
         check("tie_val", q_val[1], 500);
         check("tie_pos", q_pos[1], -20);
         check("tie_dir", q_dir[1], 0);
      end

      // each sweep value held four cycles
      reset_checks("rst4");
      eq_mode = 1'b0; pk_val = 1000; pk_pos = 5; clear_q();
      ramp(0, 20, 4, 1'b1);
      ramp(19, -20, 4, 1'b1);
      ramp(-19, 20, 4, 1'b1);
      ramp(19, -20, 4, 1'b1);
      ramp(-19, -19, 4, 1'b1);
      check("hold_ndone", q_val.size(), 3);
      if (q_val.size() == 3) begin
         check("hold_cnt", q_cnt[2], 3);
         check("hold_pos", q_pos[2], 5);
         check("hold_dir", q_dir[2], 1);
      end

      // a whole down half-scan without valid samples
      clear_q();
      ramp(-18, 20, 1, 1'b1);
      ramp(19, -20, 1, 1'b0);
      ramp(-19, 0, 1, 1'b1);
      check("novld_ndone", q_val.size(), 1);
      check("novld_cnt", int'(bus.scan_count_out), 4);
      check("novld_val", int'(bus.peak_val_out), 1000);
      check("novld_dir", int'(bus.peak_dir_out), 0);

      // enable dropped mid-scan, then restarted from 0
      clear_q();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, sigf(0), 1'b1);
      check("off_cnt", int'(bus.scan_count_out), 4);
      check("off_pos", int'(bus.peak_pos_out), 5);
      ramp(0, 30, 1, 1'b1);
      ramp(29, -30, 1, 1'b1);
      check("reen_discard", q_val.size(), 0);
      ramp(-29, 30, 1, 1'b1);
      ramp(29, 29, 1, 1'b1);
      check("reen_ndone", q_val.size(), 2);
      if (q_val.size() == 2) begin
         check("reen_cnt0", q_cnt[0], 5);
         check("reen_cnt1", q_cnt[1], 6);
      end

`ifdef SWEEP_PEAK_THRESH_EN
      reset_checks("rst_th");
      thresh = 900; pk_val = 1000; pk_pos = 5; clear_q();
      ramp(0, 20, 1, 1'b1);
      ramp(19, -20, 1, 1'b1);
      pk_val = 800;
      ramp(-19, 20, 1, 1'b1);
      ramp(19, 19, 1, 1'b1);
      check("th_ndone", q_val.size(), 2);
      if (q_val.size() == 2) begin
         check("th_found_hi", q_found[0], 1);
         check("th_found_lo", q_found[1], 0);
         check("th_val_lo", q_val[1], 800);
      end
`endif

      // one-cycle reset after activity clears every output
      reset_checks("rst_mid");

      // random walk sweep, random detector, random enable drops
      clear_q();
      pos = 0; dir = 1; amp = 40; off_left = 0;
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (off_left > 0) begin
            off_left--;
            step(1'b1, 1'b0, pos, 0, 1'b0);
            if (off_left == 0) begin pos = 0; dir = 1; end
         end else if (r == 0) begin
            off_left = int'($urandom_range(1, 5));
            step(1'b1, 1'b0, pos, 0, 1'b0);
         end else begin
            if (r < 20) begin
               // hold the current sweep value
            end else begin
               if ((pos >= amp) || (pos <= -amp) || (r == 99)) dir = -dir;
               pos = pos + dir;
            end
            if (r == 50) thresh = int'($urandom_range(0, 4000)) - 2000;
            step(1'b1, 1'b1, pos, int'($urandom_range(0, 4000)) - 2000, ($urandom_range(0, 9) != 0));
         end
      end
      check("rand_has_publishes", int'(q_val.size() > 10), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sweep_peak_finder.md
# sweep_peak_finder

- Sweep-side receiver: consumes the triangle-wave value from the sweep generator plus a detector signal (e.g. cavity transmission ADC).
- Each complete half-scan (min→max or max→min), records the largest detector sample and the sweep value where it occurred.
- Publishes the result with a one-cycle done strobe. Sits beside the sweep generator; feeds lock-acquisition logic and host readback.

## Interface
- SIGNAL_IN_SIZE, 16: width of signed detector sample (≤ 32)
- POS_SIZE, 16: width of signed sweep position (matches sweep generator output)
- clk_in  input  1  system clock; all logic on rising edge
- rst_n_in  input  1  synchronous, active-low reset
- on_in  input  1  enable; tie to the same enable that drives the sweep generator
- sweep_val_in  input  POS_SIZE  signed current sweep value, sampled every cycle
- signal_in  input  SIGNAL_IN_SIZE  signed detector sample
- signal_valid_in  input  1  signal_in qualifier; samples with this low are ignored
- peak_val_out  output  SIGNAL_IN_SIZE  signed maximum of last completed half-scan
- peak_pos_out  output  POS_SIZE  signed sweep value at that maximum
- peak_dir_out  output  1  direction of that half-scan: 0 = up, 1 = down
- done_out  output  1  one-cycle pulse when the three result outputs update
- scan_count_out  output  16  count of published half-scans; wraps 0xFFFF→0

## Operation
- States:
  - IDLE: on_in low.
  - ARM: first partial half-scan after enable; discarded.
  - SCAN: full half-scans; published.
- Direction tracking:
  - Register previous sweep value every cycle.
  - sweep_val_in > prev → dir_up; < prev → dir_down; equal → no change.
  - Turnaround = a change event whose direction differs from the stored direction.
  - Direction resets to up on entering ARM (the sweep starts at 0 going up).
- Tracker:
  - On each cycle with signal_valid_in high, a sample replaces the tracked max when signal_in > tracked max (strictly greater). Ties keep the earliest sample.
  - peak_pos is captured as sweep_val_in in the same cycle.
  - On the first valid sample of a half-scan, the tracker loads unconditionally.
- Turnaround cycle:
  - That cycle's sample belongs to the new half-scan.
  - The tracker is reloaded from that sample, or marked empty if signal_valid_in is low.
- Transitions:
  - IDLE→ARM when on_in rises.
  - ARM→SCAN on first turnaround, with no publish.
  - SCAN→SCAN on each turnaround, with publish.
  - Any state→IDLE when on_in is low.
- Publish:
  - Copy tracker to the outputs and set peak_dir_out to the direction of the finished half-scan.
  - Pulse done_out and increment scan_count_out.
  - If the finished half-scan had no valid sample, skip the publish entirely: no done_out, no count increment.
- IDLE behaviour: tracker cleared; result outputs and scan_count_out hold their last values; done_out low.
- Reset: all outputs 0, state IDLE, direction up, tracker empty.

## Timing
- Turnaround is detected combinationally from sweep_val_in vs the registered previous value in cycle N.
- Cycle N+1: done_out high, result outputs valid; the outputs stay stable until the next publish.
- The sample in cycle N is included in the next half-scan's tracker; the tracker update and the publish of the old tracker happen on the same edge.
- on_in falling in cycle N: no publish in N; state is IDLE from N+1.
- rst_n_in low overrides on_in and every other event in the same cycle.
- Maximum sustained rate: one sample per clock; no back-pressure.

## Configuration
- SWEEP_PEAK_THRESH_EN defined:
  - Adds input thresh_in (SIGNAL_IN_SIZE, signed) and output found_out (1 bit, reset 0).
  - At publish, found_out = (tracked max ≥ thresh_in), where thresh_in is sampled at publish time.
  - Results publish regardless of found_out.
- SWEEP_PEAK_THRESH_EN undefined: neither port exists; behaviour is otherwise identical.

## Structure
- Shared package/include sweep_pkg:
  - State encodings IDLE/ARM/SCAN.
  - Direction constants DIR_UP = 1'b0, DIR_DOWN = 1'b1 (same encoding as the sweep generator's GOINGUP/GOINGDOWN).
  - Default widths.
- Sub-module sweep_dir_detect:
  - Contains the previous-value register and direction register.
  - Outputs dir and a one-cycle turnaround pulse; ports clk_in, rst_n_in, clear_in, sweep_val_in.

## Test plan
- Triangle 0→+100→−100→+100 at step 1/clk, signal_in = 1000 − |pos−40| always valid:
  - No done at +100.
  - done at −100 with peak_val 1000, peak_pos 40, dir 1, count 1.
  - Next done at +100 with same val/pos, dir 0, count 2.
- Two equal maxima (500 at pos −20 and pos +30) on an up-scan: peak_pos_out = −20.
- Sweep holding each value 4 cycles (small stepsize): repeated equal values cause no false turnaround; exactly one done per half-scan.
- signal_valid_in low for an entire half-scan: no done_out, count unchanged, prior results held.
- on_in dropped mid-scan, then re-raised: outputs hold; the first half-scan after re-enable is discarded; count resumes from the held value.
- With SWEEP_PEAK_THRESH_EN, thresh_in = 900:
  - Peak 1000 → found_out = 1.
  - Peak 800 → found_out = 0 with done_out still pulsing.
  - rst_n_in low for one cycle → all outputs 0.
